// File: rtl/reward_readback.sv
// Reward table read-back: fetches the cluster, best-hop and action words from node memory
// and flags whether the stored entries agree with the local node and cluster identity.
module reward_readback #(
    parameter int WORD_WIDTH = 16,
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] MY_NODE_ID,
    input  logic [WORD_WIDTH-1:0] MY_CLUSTER_ID,
    input  logic [WORD_WIDTH-1:0] besthop,
    input  logic [WORD_WIDTH-1:0] action,
    input  logic [WORD_WIDTH-1:0] data_in,
    output logic [ADDR_WIDTH-1:0] address,
    output logic                  rd_en,
    output logic [WORD_WIDTH-1:0] cluster_entry,
    output logic [WORD_WIDTH-1:0] hop_entry,
    output logic [WORD_WIDTH-1:0] action_entry,
    output logic                  node_match,
    output logic                  cluster_match,
    output logic                  busy,
    output logic                  done
);
    localparam logic [ADDR_WIDTH-1:0] CL_BASE  = ADDR_WIDTH'(11'h148);
    localparam logic [ADDR_WIDTH-1:0] HOP_BASE = ADDR_WIDTH'(11'h1C8);
    localparam logic [ADDR_WIDTH-1:0] ACT_BASE = ADDR_WIDTH'(11'h048);

    typedef enum logic [2:0] {IDLE, ARMED, CL, HOP, ACT, CAP} state_t;
    state_t state;

    logic [WORD_WIDTH-1:0] node_id, cluster_id, cluster_idx, hop_idx, act_idx;

    // The truncating cast wraps modulo 2**ADDR_WIDTH, so index bits above [ADDR_WIDTH-2] drop out.
    function automatic logic [ADDR_WIDTH-1:0] entry_addr(input logic [ADDR_WIDTH-1:0] base,
                                                         input logic [WORD_WIDTH-1:0] idx);
        return ADDR_WIDTH'({{(WORD_WIDTH+1-ADDR_WIDTH){1'b0}}, base} + {idx, 1'b0});
    endfunction

    always_comb begin
        address = '0;
        rd_en   = 1'b0;
        case (state)
            CL:  begin address = entry_addr(CL_BASE,  cluster_idx); rd_en = 1'b1; end
            HOP: begin address = entry_addr(HOP_BASE, hop_idx);     rd_en = 1'b1; end
            ACT: begin address = entry_addr(ACT_BASE, act_idx);     rd_en = 1'b1; end
            default: ;
        endcase
    end

    assign busy = (state == ARMED) || (state == CL) || (state == HOP) ||
                  (state == ACT) || (state == CAP);

    always_ff @(posedge clock) begin
        if (rst) begin
            state         <= IDLE;
            node_id       <= '0;
            cluster_id    <= '0;
            cluster_idx   <= '0;
            hop_idx       <= '0;
            act_idx       <= '0;
            cluster_entry <= '0;
            hop_entry     <= '0;
            action_entry  <= '0;
            node_match    <= 1'b0;
            cluster_match <= 1'b0;
            done          <= 1'b0;
        end else begin
            case (state)
                IDLE: if (en) begin
                    state <= ARMED;
                    done  <= 1'b0;
                end
                ARMED: if (start) begin
                    node_id     <= MY_NODE_ID;
                    cluster_id  <= MY_CLUSTER_ID;
                    cluster_idx <= MY_CLUSTER_ID;
                    hop_idx     <= besthop;
                    act_idx     <= action;
                    state       <= CL;
                end
                CL:  state <= HOP;
                HOP: begin
                    cluster_entry <= data_in;
                    state         <= ACT;
                end
                ACT: begin
                    hop_entry <= data_in;
                    state     <= CAP;
                end
                CAP: begin
                    // action word is still on data_in here, so compare it directly
                    action_entry  <= data_in;
                    node_match    <= (cluster_entry == node_id);
                    cluster_match <= (data_in == cluster_id);
                    done          <= 1'b1;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_reward_readback.sv
// Directed bench for reward_readback with a one-cycle-latency memory model.
module tb_reward_readback;
    logic        clock = 1'b0;
    logic        rst, en, start;
    logic [15:0] MY_NODE_ID, MY_CLUSTER_ID, besthop, action, data_in;
    logic [10:0] address;
    logic        rd_en, node_match, cluster_match, busy, done;
    logic [15:0] cluster_entry, hop_entry, action_entry;
    logic [15:0] mem [0:2047];

    int tests = 0;
    int fails = 0;

    reward_readback #(.WORD_WIDTH(16), .ADDR_WIDTH(11)) dut (
        .clock(clock), .rst(rst), .en(en), .start(start),
        .MY_NODE_ID(MY_NODE_ID), .MY_CLUSTER_ID(MY_CLUSTER_ID),
        .besthop(besthop), .action(action), .data_in(data_in),
        .address(address), .rd_en(rd_en),
        .cluster_entry(cluster_entry), .hop_entry(hop_entry), .action_entry(action_entry),
        .node_match(node_match), .cluster_match(cluster_match),
        .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    // data is returned one cycle after rd_en; a marker value otherwise
    always @(posedge clock) data_in <= rd_en ? mem[address] : 16'hDEAD;

    typedef struct {
        logic [15:0] cl, hop, act, node, cid;
        logic [15:0] m_cl, m_hop, m_act;
        logic [10:0] a_cl, a_hop, a_act;
        logic        nm, cm;
    } vec_t;
    vec_t vecs [4];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic load_mem(input vec_t v);
        mem[v.a_cl]  = v.m_cl;
        mem[v.a_hop] = v.m_hop;
        mem[v.a_act] = v.m_act;
    endtask

    task automatic set_ids(input vec_t v);
        MY_CLUSTER_ID = v.cl;
        MY_NODE_ID    = v.node;
        besthop       = v.hop;
        action        = v.act;
    endtask

    // Full en/start/fetch; returns sampled in t+5.
    task automatic run_vec(input vec_t v, input string tag);
        load_mem(v);
        en = 1'b1; step(); en = 1'b0;
        check({tag, " armed busy"}, 32'(busy), 32'd1);
        check({tag, " done cleared"}, 32'(done), 32'd0);
        set_ids(v);
        // cluster-index is driven from the cluster ID port; the node identity comes separately
        MY_CLUSTER_ID = v.cl;
        start = 1'b1; step(); start = 1'b0;
        check({tag, " t+1 addr"}, 32'(address), 32'(v.a_cl));
        check({tag, " t+1 rd_en"}, 32'(rd_en), 32'd1);
        step();
        check({tag, " t+2 addr"}, 32'(address), 32'(v.a_hop));
        step();
        check({tag, " t+3 addr"}, 32'(address), 32'(v.a_act));
        step();
        check({tag, " t+4 rd_en"}, 32'(rd_en), 32'd0);
        check({tag, " t+4 done"}, 32'(done), 32'd0);
        step();
        check({tag, " cluster_entry"}, 32'(cluster_entry), 32'(v.m_cl));
        check({tag, " hop_entry"}, 32'(hop_entry), 32'(v.m_hop));
        check({tag, " action_entry"}, 32'(action_entry), 32'(v.m_act));
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " busy"}, 32'(busy), 32'd0);
        check({tag, " node_match"}, 32'(node_match), 32'(v.nm));
        check({tag, " cluster_match"}, 32'(cluster_match), 32'(v.cm));
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 16'h0;
        //          cl       hop      act      node     cid      m_cl     m_hop    m_act    a_cl    a_hop   a_act  nm cm
        vecs[0] = '{16'h0003, 16'h0005, 16'h0002, 16'h0011, 16'h0003, 16'h0011, 16'h0022, 16'h0003, 11'h14E, 11'h1D2, 11'h04C, 1, 1};
        vecs[1] = '{16'h0003, 16'h0005, 16'h0002, 16'h0011, 16'h0003, 16'h0012, 16'h0022, 16'h0003, 11'h14E, 11'h1D2, 11'h04C, 0, 1};
        vecs[2] = '{16'h03FF, 16'h0000, 16'h0400, 16'hAAAA, 16'h03FF, 16'hAAAA, 16'hBBBB, 16'h1234, 11'h146, 11'h1C8, 11'h048, 1, 0};
        vecs[3] = '{16'hFC01, 16'h03FF, 16'h03FF, 16'h0000, 16'hFC01, 16'h0000, 16'hFFFF, 16'hFC01, 11'h14A, 11'h1C6, 11'h046, 1, 1};
        // cid doubles as the cluster index, so the expected cluster_match uses m_act == cl
        rst = 1'b1; en = 1'b0; start = 1'b0;
        MY_NODE_ID = '0; MY_CLUSTER_ID = '0; besthop = '0; action = '0;
        step(); step();
        rst = 1'b0;
        check("reset address", 32'(address), 32'd0);
        check("reset rd_en", 32'(rd_en), 32'd0);
        check("reset entries", {cluster_entry, hop_entry ^ action_entry}, 32'd0);
        check("reset flags", {29'd0, node_match, cluster_match, done}, 32'd0);
        check("reset busy", 32'(busy), 32'd0);

        // start alone in IDLE does nothing
        start = 1'b1; step(); start = 1'b0;
        check("start in idle busy", 32'(busy), 32'd0);

        for (int i = 0; i < 4; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // en+start together only arms; later start launches; besthop change mid-fetch ignored
        load_mem(vecs[0]);
        set_ids(vecs[0]);
        en = 1'b1; start = 1'b1; step(); en = 1'b0; start = 1'b0;
        check("en+start rd_en", 32'(rd_en), 32'd0);
        check("en+start busy", 32'(busy), 32'd1);
        step();
        check("armed hold rd_en", 32'(rd_en), 32'd0);
        check("armed hold busy", 32'(busy), 32'd1);
        start = 1'b1; step(); start = 1'b0;
        check("late start t+1 addr", 32'(address), 32'h14E);
        step();
        besthop = 16'h0007;
        en = 1'b1;
        #1;
        check("hop change t+2 addr", 32'(address), 32'h1D2);
        step(); en = 1'b0;
        check("en ignored t+3 addr", 32'(address), 32'h04C);
        step(); step();
        check("late start hop_entry", 32'(hop_entry), 32'h0022);
        check("late start done", 32'(done), 32'd1);
        step();
        check("en in busy ignored", 32'(busy), 32'd0);

        // reset mid-fetch
        en = 1'b1; step(); en = 1'b0;
        set_ids(vecs[2]);
        start = 1'b1; step(); start = 1'b0;
        step();
        rst = 1'b1; step(); rst = 1'b0;
        check("midrst address", 32'(address), 32'd0);
        check("midrst rd_en", 32'(rd_en), 32'd0);
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst done", 32'(done), 32'd0);
        check("midrst entries", {cluster_entry, hop_entry | action_entry}, 32'd0);
        check("midrst flags", {30'd0, node_match, cluster_match}, 32'd0);
        step();
        check("midrst stays idle", 32'(busy), 32'd0);
        run_vec(vecs[0], "postrst");

        // done is sticky through idle, clears after the next en
        for (int i = 0; i < 10; i++) begin
            step();
            check($sformatf("sticky done %0d", i), 32'(done), 32'd1);
        end
        en = 1'b1; step(); en = 1'b0;
        check("done cleared by en", 32'(done), 32'd0);
        check("entry held after en", 32'(cluster_entry), 32'h0011);
        check("flags held after en", {30'd0, node_match, cluster_match}, 32'd3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1, "timeout");
    end
endmodule
